// File: rtl/ofm_result_checker.sv
// Sweeps the OFM result RAM against a golden RAM line by line and reports pass/fail,
// a saturating mismatch count and the first failing element. Optional: OFM_CHECK_TOLERANCE_EN.
module ofm_result_checker #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 16,
  parameter int ADDR_WIDTH = 20,
  parameter int RD_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         total_words,
  input  logic [DATA_WIDTH-1:0]         tolerance,
  input  logic                          stop_on_first,
  output logic                          rd_en,
  output logic [ADDR_WIDTH-1:0]         rd_addr,
  input  logic [LANES*DATA_WIDTH-1:0]   dut_rd_data,
  input  logic [LANES*DATA_WIDTH-1:0]   gold_rd_data,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [ADDR_WIDTH-1:0]         err_count,
  output logic [ADDR_WIDTH-1:0]         first_err_addr,
  output logic [DATA_WIDTH-1:0]         first_err_dut,
  output logic [DATA_WIDTH-1:0]         first_err_gold
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam int EW = ADDR_WIDTH + $clog2(LANES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  function automatic logic lane_mismatch(input logic [DATA_WIDTH-1:0] d,
                                         input logic [DATA_WIDTH-1:0] g,
                                         input logic [DATA_WIDTH-1:0] tol);
`ifdef OFM_CHECK_TOLERANCE_EN
    logic [DATA_WIDTH:0] diff;
    logic [DATA_WIDTH:0] mag;
    diff = {d[DATA_WIDTH-1], d} - {g[DATA_WIDTH-1], g};
    mag  = diff[DATA_WIDTH] ? -diff : diff;
    return mag > {1'b0, tol};
`else
    logic tol_unused;
    tol_unused = ^tol;
    return d != g;
`endif
  endfunction

  state_t                  r_state, w_next;
  logic                    r_rd_en, r_busy, r_done, r_pass, r_stop;
  logic [ADDR_WIDTH-1:0]   r_rd_addr, r_total, r_num_lines, r_err;
  logic [DATA_WIDTH-1:0]   r_tol;
  logic [RD_LATENCY-1:0]   r_vld;
  logic [ADDR_WIDTH-1:0]   r_vaddr [RD_LATENCY];
  logic                    r_cmp_vld;
  logic [LANES-1:0]        r_cmp_mis;
  logic [ADDR_WIDTH-1:0]   r_cmp_faddr, r_first_addr;
  logic [DATA_WIDTH-1:0]   r_cmp_fdut, r_cmp_fgold, r_first_dut, r_first_gold;

  logic                    w_start_ok, w_read_end;
  logic [ADDR_WIDTH-1:0]   w_lines;
  logic [EW-1:0]           w_base, w_elem;
  logic [LANES-1:0]        w_mis;
  logic [ADDR_WIDTH-1:0]   w_faddr;
  logic [DATA_WIDTH-1:0]   w_fdut, w_fgold;
  logic [CW-1:0]           w_pop, w_sum;

  // start arriving in the same cycle as done belongs to the finished sweep
  assign w_start_ok = start && !r_done;
  assign w_lines    = ADDR_WIDTH'((CW'(total_words) + CW'(LANES - 1)) / CW'(LANES));
  assign w_read_end = !r_rd_en || (r_rd_addr == r_num_lines - ADDR_WIDTH'(1))
                      || (r_stop && r_cmp_vld && (|r_cmp_mis));

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next = S_READ; else w_next = S_IDLE;
      S_READ:  if (w_read_end) w_next = S_DRAIN; else w_next = S_READ;
      S_DRAIN: if (!(|r_vld) && !r_cmp_vld) w_next = S_DONE; else w_next = S_DRAIN;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Read issue and sweep configuration capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_en <= 1'b0; r_rd_addr <= '0; r_busy <= 1'b0; r_done <= 1'b0;
      r_total <= '0; r_num_lines <= '0; r_tol <= '0; r_stop <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (r_state == S_DONE);
      if (r_state == S_IDLE && w_start_ok) begin
        r_total     <= total_words;
        r_num_lines <= w_lines;
        r_tol       <= tolerance;
        r_stop      <= stop_on_first;
        r_rd_en     <= (total_words != '0);
        r_rd_addr   <= '0;
      end else if (r_state == S_READ && w_next == S_READ) begin
        if (r_rd_en) r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
        else         r_rd_addr <= r_rd_addr;
      end else begin
        r_rd_en   <= 1'b0;
        r_rd_addr <= '0;
      end
    end
  end

  // Per-lane compare of the returning line; descending scan leaves the lowest lane as first
  always_comb begin
    w_base  = EW'(r_vaddr[RD_LATENCY-1]) * EW'(LANES);
    w_elem  = '0;
    w_mis   = '0;
    w_faddr = '0;
    w_fdut  = '0;
    w_fgold = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      w_elem = w_base + EW'(k);
      if ((w_elem < EW'(r_total)) &&
          lane_mismatch(dut_rd_data[k*DATA_WIDTH +: DATA_WIDTH],
                        gold_rd_data[k*DATA_WIDTH +: DATA_WIDTH], r_tol)) begin
        w_mis[k] = 1'b1;
        w_faddr  = ADDR_WIDTH'(w_elem);
        w_fdut   = dut_rd_data[k*DATA_WIDTH +: DATA_WIDTH];
        w_fgold  = gold_rd_data[k*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        w_mis[k] = 1'b0;
      end
    end
  end

  // Read-latency tracking and registered compare stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_vaddr[i] <= '0;
      r_cmp_vld <= 1'b0; r_cmp_mis <= '0;
      r_cmp_faddr <= '0; r_cmp_fdut <= '0; r_cmp_fgold <= '0;
    end else begin
      r_vld[0]   <= r_rd_en;
      r_vaddr[0] <= r_rd_addr;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_vld[i]   <= r_vld[i-1];
        r_vaddr[i] <= r_vaddr[i-1];
      end
      r_cmp_vld <= r_vld[RD_LATENCY-1];
      if (r_vld[RD_LATENCY-1]) r_cmp_mis <= w_mis;
      else                     r_cmp_mis <= '0;
      r_cmp_faddr <= w_faddr;
      r_cmp_fdut  <= w_fdut;
      r_cmp_fgold <= w_fgold;
    end
  end

  // Line popcount and saturating accumulate
  always_comb begin
    w_pop = '0;
    for (int k = 0; k < LANES; k++) w_pop = w_pop + CW'(r_cmp_mis[k]);
    w_sum = {1'b0, r_err} + w_pop;
  end

  // Result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= '0; r_pass <= 1'b0;
      r_first_addr <= '0; r_first_dut <= '0; r_first_gold <= '0;
    end else if (r_state == S_IDLE && w_start_ok) begin
      r_err <= '0; r_pass <= 1'b0;
      r_first_addr <= '0; r_first_dut <= '0; r_first_gold <= '0;
    end else begin
      if (r_cmp_vld) begin
        r_err <= w_sum[CW-1] ? '1 : w_sum[ADDR_WIDTH-1:0];
        if (r_err == '0 && (|r_cmp_mis)) begin
          r_first_addr <= r_cmp_faddr;
          r_first_dut  <= r_cmp_fdut;
          r_first_gold <= r_cmp_fgold;
        end
      end
      if (r_state == S_DONE) r_pass <= (r_err == '0);
    end
  end

  assign rd_en          = r_rd_en;
  assign rd_addr        = r_rd_addr;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err;
  assign first_err_addr = r_first_addr;
  assign first_err_dut  = r_first_dut;
  assign first_err_gold = r_first_gold;
endmodule

// File: tb/tb_ofm_result_checker.sv
// Scoreboard bench for ofm_result_checker: directed sweeps push expected results, a monitor checks on done.
module tb_ofm_result_checker;
  localparam int DW = 16;
  localparam int LN = 16;
  localparam int AW = 20;
  localparam int RL = 2;
  localparam int MEMSZ = 5424;

  typedef struct {
    int err; int pass; int fa; int fd; int fg; int reads; int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [AW-1:0] total_words = '0;
  logic [DW-1:0] tolerance = '0;
  logic stop_on_first = 1'b0;
  logic rd_en, busy, done, pass;
  logic [AW-1:0] rd_addr, err_count, first_err_addr;
  logic [DW-1:0] first_err_dut, first_err_gold;
  logic [LN*DW-1:0] dut_rd_data, gold_rd_data;

  logic [DW-1:0] dmem [MEMSZ];
  logic [DW-1:0] gmem [MEMSZ];
  logic [LN*DW-1:0] dp [RL];
  logic [LN*DW-1:0] gp [RL];

  int cyc = 0;
  int rd_cnt = 0;
  int rd_base = 0;
  int t_start = 0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];

  ofm_result_checker #(.DATA_WIDTH(DW), .LANES(LN), .ADDR_WIDTH(AW), .RD_LATENCY(RL)) dut (
    .clk(clk), .rst(rst), .start(start), .total_words(total_words),
    .tolerance(tolerance), .stop_on_first(stop_on_first),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .dut_rd_data(dut_rd_data), .gold_rd_data(gold_rd_data),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_dut(first_err_dut),
    .first_err_gold(first_err_gold)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: data for a read issued at edge E is presented RL-1 edges later
  always @(posedge clk) begin
    if (rd_en) begin
      for (int k = 0; k < LN; k++) begin
        dp[0][k*DW +: DW] <= dmem[int'(rd_addr)*LN + k];
        gp[0][k*DW +: DW] <= gmem[int'(rd_addr)*LN + k];
      end
    end
    for (int i = 1; i < RL; i++) begin
      dp[i] <= dp[i-1];
      gp[i] <= gp[i-1];
    end
  end
  assign dut_rd_data  = dp[RL-1];
  assign gold_rd_data = gp[RL-1];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input int err, input int ps, input int fa, input int fd,
                              input int fg, input int reads, input int lat);
    exp_t e;
    e.err = err; e.pass = ps; e.fa = fa; e.fd = fd; e.fg = fg; e.reads = reads; e.lat = lat;
    return e;
  endfunction

  // Monitor: pops one expectation per done pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_en) rd_cnt++;
      if (done) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: done pulsed at cycle %0d with no sweep pending", cyc);
        end else begin
          e = q.pop_front();
          chk("err_count", int'(err_count), e.err);
          chk("pass", int'(pass), e.pass);
          chk("first_err_addr", int'(first_err_addr), e.fa);
          chk("first_err_dut", int'(first_err_dut), e.fd);
          chk("first_err_gold", int'(first_err_gold), e.fg);
          chk("reads", rd_cnt - rd_base, e.reads);
          chk("done_latency", cyc - t_start, e.lat);
        end
      end
    end
  end

  task automatic fill();
    for (int i = 0; i < MEMSZ; i++) begin
      gmem[i] = 16'(i * 7 + 3);
      dmem[i] = gmem[i];
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within 4000 cycles");
    end
  endtask

  task automatic sweep(input int tw, input int tol, input bit stp, input exp_t e);
    @(negedge clk);
    total_words = AW'(tw);
    tolerance = DW'(tol);
    stop_on_first = stp;
    start = 1'b1;
    t_start = cyc + 1;
    rd_base = rd_cnt;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_done();
  endtask

  initial begin
    fill();
    repeat (3) @(negedge clk);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_faddr", int'(first_err_addr), 0);
    chk("rst_fdut", int'(first_err_dut), 0);
    rst = 1'b0;

    // identical RAMs: 338 lines, done at T+338+RL+3
    sweep(5408, 0, 1'b0, mk(0, 1, 0, 0, 0, 338, 343));

    // single mismatch at element 1000
    gmem[1000] = 16'd7; dmem[1000] = 16'd9;
    sweep(5408, 0, 1'b0, mk(1, 0, 1000, 9, 7, 338, 343));

    // start while done is high must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_at_done_busy", int'(busy), 0);
    chk("start_at_done_rd_en", int'(rd_en), 0);

`ifdef OFM_CHECK_TOLERANCE_EN
    sweep(5408, 2, 1'b0, mk(0, 1, 0, 0, 0, 338, 343));
`else
    sweep(5408, 2, 1'b0, mk(1, 0, 1000, 9, 7, 338, 343));
`endif
    sweep(5408, 1, 1'b0, mk(1, 0, 1000, 9, 7, 338, 343));

    // stop_on_first: lines 0..3 issued, line 2 in flight adds element 40
    fill();
    dmem[5] = 16'h1234; dmem[9] = gmem[9] + 16'd1; dmem[40] = gmem[40] + 16'd1;
    sweep(5408, 0, 1'b1, mk(3, 0, 5, 'h1234, 38, 4, 9));

    // masked tail lanes of the last line
    fill();
    for (int i = 20; i < 32; i++) dmem[i] = gmem[i] ^ 16'h00FF;
    sweep(20, 0, 1'b0, mk(0, 1, 0, 0, 0, 2, 7));
    dmem[19] = gmem[19] + 16'd1;
    sweep(20, 0, 1'b0, mk(1, 0, 19, 137, 136, 2, 7));

    // empty sweep
    sweep(0, 0, 1'b0, mk(0, 1, 0, 0, 0, 0, 3));

    // extreme signed difference: 32767 - (-32768) = 65535
    fill();
    gmem[100] = 16'h8000; dmem[100] = 16'h7FFF;
`ifdef OFM_CHECK_TOLERANCE_EN
    sweep(128, 'hFFFF, 1'b0, mk(0, 1, 0, 0, 0, 8, 13));
`else
    sweep(128, 'hFFFF, 1'b0, mk(1, 0, 100, 32767, 32768, 8, 13));
`endif

    // reset in the middle of READ
    fill();
    @(negedge clk);
    total_words = AW'(5408); tolerance = '0; stop_on_first = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_rd_en", int'(rd_en), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_rd_en", int'(rd_en), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_rd_addr", int'(rd_addr), 0);
    chk("mid_rst_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    sweep(64, 0, 1'b0, mk(0, 1, 0, 0, 0, 4, 9));

    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
